// File: rtl/add_nib_seq_if.sv
// Operand/result bundle for the nibble-serial add/sub sequencer.
// The issuing block owns the master side; add_nib_seq owns the slave side.
interface add_nib_seq_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] s_o;
  logic             c_o;
  logic             v_o;
  logic             z_o;
  logic             n_o;

  modport master (
    output start_i, sub_i, a_i, b_i,
    input  busy_o, done_o, s_o, c_o, v_o, z_o, n_o
  );

  modport slave (
    input  start_i, sub_i, a_i, b_i,
    output busy_o, done_o, s_o, c_o, v_o, z_o, n_o
  );
endinterface

// File: rtl/add_nib_seq.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single 4-bit
// add/sub slice, LSB first, with the inter-nibble carry held in a register.
module add_nib_seq #(
  parameter int WIDTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  add_nib_seq_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic [3:0]       a_nib, b_nib, sum_nib;
  logic             slice_c;
  logic [WIDTH-1:0] acc_fin;
  logic             accept;
  logic             last_nib;

  // 4-bit add/sub slice: B is inverted for subtract, carry-in seeds the +1.
  assign a_nib              = 4'(a_q >> (4 * k_q));
  assign b_nib              = 4'(b_q >> (4 * k_q));
  assign {slice_c, sum_nib} = {1'b0, a_nib} + {1'b0, b_nib ^ {4{sub_q}}} + {4'b0, carry_q};

  assign accept   = bus.start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_nib = (k_q == KW'(NIB - 1));

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    acc_fin = acc_q;
    for (int i = 0; i < NIB; i++) begin
      if (k_q == KW'(i)) acc_fin[i*4 +: 4] = sum_nib;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;

    if (accept) begin
      a_d     = bus.a_i;
      b_d     = bus.b_i;
      sub_d   = bus.sub_i;
      carry_d = bus.sub_i;
      acc_d   = '0;
      k_d     = '0;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_d   = acc_fin;
          carry_d = slice_c;
          if (last_nib) begin
            state_d = S_DONE;
            k_d     = '0;
            s_d     = acc_fin;
            c_d     = slice_c;
            n_d     = acc_fin[WIDTH-1];
            z_d     = (acc_fin == '0);
            // Overflow: operands (B after optional inversion) agree in sign, result does not.
            v_d     = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                      (acc_fin[WIDTH-1] != a_q[WIDTH-1]);
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values; reset clears every register, an aborted
  // operation leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign bus.busy_o = (state_q == S_RUN);
  assign bus.done_o = (state_q == S_DONE);
  assign bus.s_o    = s_q;
  assign bus.c_o    = c_q;
  assign bus.v_o    = v_q;
  assign bus.z_o    = z_q;
  assign bus.n_o    = n_q;
endmodule

// File: tb/tb_add_nib_seq.sv
// Directed-vector bench for add_nib_seq at WIDTH=16: arithmetic, flags,
// latency, handshake corner cases and reset behaviour.
module tb_add_nib_seq;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  add_nib_seq_if #(.WIDTH(16)) bus ();

  add_nib_seq #(.WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  // Launch one operation and wait (bounded) for done_o; inputs are scrambled
  // right after the accepting edge to show the operands were latched.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat, output int busy_cnt, output bit got);
    @(negedge clk);
    bus.a_i = a; bus.b_i = b; bus.sub_i = sub; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0; bus.a_i = 16'hDEAD; bus.b_i = 16'hBEEF; bus.sub_i = ~sub;
    lat = 0; busy_cnt = 0; got = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (bus.done_o) begin got = 1'b1; break; end
      if (bus.busy_o) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.sub_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o} !== 20'h0) begin
      $display("FAIL reset_outputs: got s=%h cvzn=%b%b%b%b, want all 0",
               bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o);
      miscompares++;
    end
    vectors++;
    if ({bus.busy_o, bus.done_o} !== 2'b00) begin
      $display("FAIL reset_busy_done: got busy=%b done=%b, want 0 0", bus.busy_o, bus.done_o);
      miscompares++;
    end
    rst_n = 1'b1;
    begin
      int dones = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.done_o || bus.busy_o) dones++;
      end
      vectors++;
      if (dones !== 0) begin
        $display("FAIL reset_idle_quiet: got %0d active cycles, want 0", dones);
        miscompares++;
      end
    end
  endtask

  task automatic test_arith();
    vec_t tbl[5];
    int   lat, busy_cnt;
    bit   got;
    tbl[0] = '{"add_basic",  16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{"add_carry0", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{"add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{"sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{"sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, lat, busy_cnt, got);
      vectors++;
      if (!got) begin
        $display("FAIL %s_timeout: got no done_o, want done_o within 20 cycles", tbl[i].name);
        miscompares++;
      end else begin
        if ({bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o} !==
            {tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n}) begin
          $display("FAIL %s_result: got s=%h cvzn=%b%b%b%b, want s=%h cvzn=%b%b%b%b", tbl[i].name,
                   bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o,
                   tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n);
          miscompares++;
        end
        vectors++;
        if (lat !== 4 || busy_cnt !== 4 || bus.busy_o !== 1'b0) begin
          $display("FAIL %s_timing: got latency=%0d busy_cycles=%0d busy_at_done=%b, want 4 4 0",
                   tbl[i].name, lat, busy_cnt, bus.busy_o);
          miscompares++;
        end
      end
      @(negedge clk);
      vectors++;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        $display("FAIL %s_pulse: got done=%b busy=%b after done cycle, want 0 0",
                 tbl[i].name, bus.done_o, bus.busy_o);
        miscompares++;
      end
    end
  endtask

  task automatic test_start_in_run();
    int dones = 0;
    logic [15:0] s_seen = '0;
    @(negedge clk);
    bus.a_i = 16'h0010; bus.b_i = 16'h0020; bus.sub_i = 1'b0; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0; bus.a_i = 16'hFFFF; bus.b_i = 16'hFFFF;
    @(posedge clk);
    #1 bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done_o) begin dones++; s_seen = bus.s_o; end
    end
    vectors++;
    if (dones !== 1) begin
      $display("FAIL run_start_ignored: got %0d done pulses, want 1", dones);
      miscompares++;
    end
    vectors++;
    if (s_seen !== 16'h0030) begin
      $display("FAIL run_start_result: got s=%h, want 0030", s_seen);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, first = -1, second = -1;
    @(negedge clk);
    bus.a_i = 16'h1111; bus.b_i = 16'h2222; bus.sub_i = 1'b0; bus.start_i = 1'b1;
    for (int i = 0; i < 30 && second < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o) begin
        vectors++;
        if (bus.busy_o !== 1'b0) begin
          $display("FAIL b2b_busy_done: got busy=1 with done=1, want busy=0");
          miscompares++;
        end
        if (first < 0) begin
          first = cyc;
          vectors++;
          if (bus.s_o !== 16'h3333) begin
            $display("FAIL b2b_first: got s=%h, want 3333", bus.s_o);
            miscompares++;
          end
          bus.a_i = 16'h00FF; bus.b_i = 16'h0F01;
        end else begin
          second = cyc;
          vectors++;
          if ({bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o} !== {16'h1000, 4'b0000}) begin
            $display("FAIL b2b_second: got s=%h cvzn=%b%b%b%b, want s=1000 cvzn=0000",
                     bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o);
            miscompares++;
          end
          bus.start_i = 1'b0;
        end
      end
    end
    bus.start_i = 1'b0;
    vectors++;
    if (second < 0 || second - first !== 5) begin
      $display("FAIL b2b_spacing: got first=%0d second=%0d, want second-first=5", first, second);
      miscompares++;
    end
  endtask

  task automatic test_hold_idle();
    int dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    vectors++;
    if (bus.s_o !== 16'h1000 || dones !== 0) begin
      $display("FAIL idle_hold: got s=%h dones=%0d, want s=1000 dones=0", bus.s_o, dones);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0, lat, busy_cnt;
    bit got;
    @(negedge clk);
    bus.a_i = 16'hFFFF; bus.b_i = 16'h0001; bus.sub_i = 1'b0; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o, bus.busy_o, bus.done_o} !== 22'h0) begin
      $display("FAIL midrun_reset_outputs: got s=%h cvzn=%b%b%b%b busy=%b done=%b, want all 0",
               bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o, bus.busy_o, bus.done_o);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      $display("FAIL midrun_no_done: got %0d done pulses, want 0", dones);
      miscompares++;
    end
    run_op(16'h0001, 16'h0001, 1'b0, lat, busy_cnt, got);
    vectors++;
    if (!got || {bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o} !== {16'h0002, 4'b0000}) begin
      $display("FAIL midrun_after_add: got done=%b s=%h cvzn=%b%b%b%b, want done=1 s=0002 cvzn=0000",
               got, bus.s_o, bus.c_o, bus.v_o, bus.z_o, bus.n_o);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_arith();
    test_start_in_run();
    test_back_to_back();
    test_hold_idle();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
